// File: rtl/vending_pkg.sv
// Shared types and default sizing for the change-return controller.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNT    = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam int DEF_NUM_COINS   = 3;
  localparam int DEF_TOTAL_BITS  = 31;
  localparam int DEF_WAIT_CYCLES = 10;
  localparam int DEF_INV_BITS    = 8;

endpackage

// File: rtl/return_change_ctrl_if.sv
// Coin-selection bundle: the controller offers balance/inventory, the selector answers with a coin.
interface return_change_ctrl_if
  import vending_pkg::*;
#(
  parameter int NUM_COINS  = DEF_NUM_COINS,
  parameter int TOTAL_BITS = DEF_TOTAL_BITS,
  parameter int INV_BITS   = DEF_INV_BITS
);
  localparam int IW = $clog2(NUM_COINS);

  logic [NUM_COINS*TOTAL_BITS-1:0] values;
  logic [NUM_COINS*INV_BITS-1:0]   inv;
  logic [TOTAL_BITS-1:0]           remaining;
  logic                            valid;
  logic [IW-1:0]                   idx;

  // valid/idx are a pure function of values/inv/remaining in the same cycle; no handshake.
  modport master (output values, output inv, output remaining, input valid, input idx);
  modport slave  (input values, input inv, input remaining, output valid, output idx);
endinterface

// File: rtl/return_change_ctrl_coin_select.sv
// Greedy selector: largest denomination that fits the remaining balance and is in stock.
module coin_select
  import vending_pkg::*;
#(
  parameter int NUM_COINS  = DEF_NUM_COINS,
  parameter int TOTAL_BITS = DEF_TOTAL_BITS,
  parameter int INV_BITS   = DEF_INV_BITS
) (
  return_change_ctrl_if.slave sel
);
  localparam int IW = $clog2(NUM_COINS);

  // Ascending scan so the last eligible (largest) denomination wins.
  always_comb begin
    sel.valid = 1'b0;
    sel.idx   = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (sel.values[k*TOTAL_BITS +: TOTAL_BITS] <= sel.remaining &&
          sel.inv[k*INV_BITS +: INV_BITS] != '0) begin
        sel.valid = 1'b1;
        sel.idx   = IW'(k);
      end
    end
  end
endmodule

// File: rtl/return_change_ctrl.sv
// Change-return controller: idle timeout / user trigger, then ejects coins greedily one per handshake.
module return_change_ctrl
  import vending_pkg::*;
#(
  parameter int NUM_COINS   = DEF_NUM_COINS,
  parameter int TOTAL_BITS  = DEF_TOTAL_BITS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int INV_BITS    = DEF_INV_BITS
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_COINS*TOTAL_BITS-1:0]    i_coin_values,
  input  logic [TOTAL_BITS-1:0]              i_current_total,
  input  logic                               i_activity,
  input  logic                               i_trigger_return,
  input  logic                               i_inv_load,
  input  logic [NUM_COINS*INV_BITS-1:0]      i_inv_counts,
  input  logic [NUM_COINS-1:0]               i_inv_add,
  input  logic                               i_coin_ready,
  output logic                               o_coin_valid,
  output logic [$clog2(NUM_COINS)-1:0]       o_coin_idx,
  output logic [TOTAL_BITS-1:0]              o_return_total,
  output logic [TOTAL_BITS-1:0]              o_residual,
  output logic                               o_done,
  output logic                               o_busy,
  output logic [$clog2(WAIT_CYCLES+1)-1:0]   o_wait_time
);
  localparam int IW = $clog2(NUM_COINS);
  localparam int TW = $clog2(WAIT_CYCLES+1);
  localparam logic [TW-1:0] WAIT_INIT = TW'(WAIT_CYCLES);

  state_t                        r_state;
  logic [TW-1:0]                 r_timer;
  logic [NUM_COINS*INV_BITS-1:0] r_inv;
  logic [TOTAL_BITS-1:0]         r_remaining;
  logic [TOTAL_BITS-1:0]         r_return_total;
  logic [TOTAL_BITS-1:0]         r_residual;
  logic                          r_coin_valid;
  logic [IW-1:0]                 r_coin_idx;
  logic                          r_done;

  logic                          w_accept;
  logic [TOTAL_BITS-1:0]         w_acc_value;
  logic [TOTAL_BITS-1:0]         w_rem_after;
  logic [TOTAL_BITS-1:0]         w_ret_after;
  logic [NUM_COINS*INV_BITS-1:0] w_inv_next;

  // o_coin_valid is only ever set in DISPENSE, so this is the accept strobe.
  assign w_accept = r_coin_valid && i_coin_ready;

  always_comb begin
    w_acc_value = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (w_accept && r_coin_idx == IW'(k))
        w_acc_value = i_coin_values[k*TOTAL_BITS +: TOTAL_BITS];
    end
  end

  assign w_rem_after = r_remaining - w_acc_value;
  assign w_ret_after = r_return_total + w_acc_value;

  // Deposit and eject of the same denomination in one cycle cancel out.
  always_comb begin
    w_inv_next = r_inv;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (i_inv_load) begin
        w_inv_next[k*INV_BITS +: INV_BITS] = i_inv_counts[k*INV_BITS +: INV_BITS];
      end else if (i_inv_add[k] && !(w_accept && r_coin_idx == IW'(k))) begin
        if (r_inv[k*INV_BITS +: INV_BITS] != {INV_BITS{1'b1}})
          w_inv_next[k*INV_BITS +: INV_BITS] = r_inv[k*INV_BITS +: INV_BITS] + INV_BITS'(1);
      end else if (!i_inv_add[k] && w_accept && r_coin_idx == IW'(k)) begin
        w_inv_next[k*INV_BITS +: INV_BITS] = r_inv[k*INV_BITS +: INV_BITS] - INV_BITS'(1);
      end
    end
  end

  // Selection looks at post-accept state so back-to-back coins need no bubble.
  return_change_ctrl_if #(
    .NUM_COINS (NUM_COINS),
    .TOTAL_BITS(TOTAL_BITS),
    .INV_BITS  (INV_BITS)
  ) u_sel_if ();

  assign u_sel_if.values    = i_coin_values;
  assign u_sel_if.inv       = w_inv_next;
  assign u_sel_if.remaining = w_rem_after;

  coin_select #(
    .NUM_COINS (NUM_COINS),
    .TOTAL_BITS(TOTAL_BITS),
    .INV_BITS  (INV_BITS)
  ) u_coin_select (
    .sel(u_sel_if)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_timer        <= WAIT_INIT;
      r_inv          <= '0;
      r_remaining    <= '0;
      r_return_total <= '0;
      r_residual     <= '0;
      r_coin_valid   <= 1'b0;
      r_coin_idx     <= '0;
      r_done         <= 1'b0;
    end else begin
      r_inv <= w_inv_next;
      case (r_state)
        ST_IDLE: begin
          r_timer <= WAIT_INIT;
          r_done  <= 1'b0;
          if (i_trigger_return) begin
            r_state        <= ST_DISPENSE;
            r_remaining    <= i_current_total;
            r_return_total <= '0;
            r_residual     <= '0;
            r_coin_valid   <= 1'b0;
          end else if (i_current_total != '0) begin
            r_state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (i_trigger_return || r_timer == TW'(1) || r_timer == '0) begin
            if (!i_trigger_return) r_timer <= '0;
            r_state        <= ST_DISPENSE;
            r_remaining    <= i_current_total;
            r_return_total <= '0;
            r_residual     <= '0;
            r_coin_valid   <= 1'b0;
          end else if (i_current_total == '0) begin
            r_state <= ST_IDLE;
            r_timer <= WAIT_INIT;
          end else if (i_activity) begin
            r_timer <= WAIT_INIT;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        ST_DISPENSE: begin
          // A presented coin is frozen until the ejector takes it.
          if (!r_coin_valid || i_coin_ready) begin
            r_remaining    <= w_rem_after;
            r_return_total <= w_ret_after;
            r_coin_valid   <= u_sel_if.valid;
            r_coin_idx     <= u_sel_if.idx;
            if (!u_sel_if.valid) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_residual <= w_rem_after;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_timer <= WAIT_INIT;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_coin_valid   = r_coin_valid;
  assign o_coin_idx     = r_coin_idx;
  assign o_return_total = r_return_total;
  assign o_residual     = r_residual;
  assign o_done         = r_done;
  assign o_busy         = (r_state == ST_DISPENSE) || (r_state == ST_DONE);
  assign o_wait_time    = r_timer;

endmodule

// File: tb/tb_return_change_ctrl.sv
// Directed bench for return_change_ctrl with denominations 100/500/1000 and a 10-cycle timeout.
module tb_return_change_ctrl;
  import vending_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [92:0] i_coin_values;
  logic [30:0] i_current_total = '0;
  logic        i_activity = 1'b0;
  logic        i_trigger_return = 1'b0;
  logic        i_inv_load = 1'b0;
  logic [23:0] i_inv_counts = '0;
  logic [2:0]  i_inv_add = '0;
  logic        i_coin_ready = 1'b0;
  logic        o_coin_valid;
  logic [1:0]  o_coin_idx;
  logic [30:0] o_return_total;
  logic [30:0] o_residual;
  logic        o_done;
  logic        o_busy;
  logic [3:0]  o_wait_time;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  return_change_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_coin_values   (i_coin_values),
    .i_current_total (i_current_total),
    .i_activity      (i_activity),
    .i_trigger_return(i_trigger_return),
    .i_inv_load      (i_inv_load),
    .i_inv_counts    (i_inv_counts),
    .i_inv_add       (i_inv_add),
    .i_coin_ready    (i_coin_ready),
    .o_coin_valid    (o_coin_valid),
    .o_coin_idx      (o_coin_idx),
    .o_return_total  (o_return_total),
    .o_residual      (o_residual),
    .o_done          (o_done),
    .o_busy          (o_busy),
    .o_wait_time     (o_wait_time)
  );

  // Standalone selector exercised directly with hand-picked vectors.
  return_change_ctrl_if #(.NUM_COINS(3), .TOTAL_BITS(31), .INV_BITS(8)) tb_sel_if ();
  coin_select #(.NUM_COINS(3), .TOTAL_BITS(31), .INV_BITS(8)) u_ref_sel (.sel(tb_sel_if));

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    i_coin_values = {31'd1000, 31'd500, 31'd100};

    // selector alone
    tb_sel_if.values    = {31'd1000, 31'd500, 31'd100};
    tb_sel_if.inv       = {8'd1, 8'd1, 8'd1};
    tb_sel_if.remaining = 31'd1600;
    #1;
    check("sel_1600_valid", tb_sel_if.valid, 1);
    check("sel_1600_idx", tb_sel_if.idx, 2);
    tb_sel_if.remaining = 31'd99;
    #1;
    check("sel_99_valid", tb_sel_if.valid, 0);
    tb_sel_if.inv       = {8'd1, 8'd0, 8'd1};
    tb_sel_if.remaining = 31'd999;
    #1;
    check("sel_skip_empty_idx", tb_sel_if.idx, 0);

    // reset state
    step(2);
    check("rst_valid", o_coin_valid, 0);
    check("rst_done", o_done, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ret", o_return_total, 0);
    check("rst_resid", o_residual, 0);
    check("rst_wait", o_wait_time, 10);
    check("rst_state", dut.r_state, ST_IDLE);
    reset_n = 1'b1;

    i_inv_load = 1'b1;
    i_inv_counts = {8'd8, 8'd8, 8'd8};
    step(1);
    i_inv_load = 1'b0;
    check("inv_loaded", dut.r_inv, 24'h080808);

    // 1600 returned as 1000, 500, 100
    i_current_total = 31'd1600;
    i_trigger_return = 1'b1;
    step(1);
    i_trigger_return = 1'b0;
    i_current_total = '0;
    check("t1_busy", o_busy, 1);
    check("t1_valid_bubble", o_coin_valid, 0);
    i_coin_ready = 1'b1;
    step(1);
    check("t1_c0_valid", o_coin_valid, 1);
    check("t1_c0_idx", o_coin_idx, 2);
    step(1);
    check("t1_c1_idx", o_coin_idx, 1);
    check("t1_c1_ret", o_return_total, 1000);
    step(1);
    check("t1_c2_idx", o_coin_idx, 0);
    check("t1_c2_ret", o_return_total, 1500);
    step(1);
    check("t1_done", o_done, 1);
    check("t1_ret", o_return_total, 1600);
    check("t1_resid", o_residual, 0);
    check("t1_valid_off", o_coin_valid, 0);
    step(1);
    check("t1_done_pulse", o_done, 0);
    check("t1_idle_busy", o_busy, 0);
    check("t1_inv", dut.r_inv, 24'h070707);

    // timeout with no activity
    i_coin_ready = 1'b0;
    i_current_total = 31'd500;
    step(1);
    check("t2_count", dut.r_state, ST_COUNT);
    check("t2_wait10", o_wait_time, 10);
    step(9);
    check("t2_wait1", o_wait_time, 1);
    check("t2_still_count", dut.r_state, ST_COUNT);
    step(1);
    check("t2_dispense", dut.r_state, ST_DISPENSE);
    i_current_total = '0;
    i_coin_ready = 1'b1;
    step(2);
    check("t2_done", o_done, 1);
    check("t2_ret", o_return_total, 500);
    step(1);

    // activity at countdown 5 restarts the full wait
    i_current_total = 31'd500;
    step(1);
    step(5);
    check("t3_wait5", o_wait_time, 5);
    i_activity = 1'b1;
    step(1);
    i_activity = 1'b0;
    check("t3_reload", o_wait_time, 10);
    step(9);
    check("t3_count", dut.r_state, ST_COUNT);
    step(1);
    check("t3_dispense", dut.r_state, ST_DISPENSE);
    i_current_total = '0;
    step(2);
    check("t3_ret", o_return_total, 500);
    step(1);
    check("t3_inv", dut.r_inv, 24'h070507);

    // ejector stalls for 4 cycles
    i_coin_ready = 1'b0;
    i_current_total = 31'd1000;
    i_trigger_return = 1'b1;
    step(1);
    i_trigger_return = 1'b0;
    i_current_total = '0;
    step(1);
    i_inv_add = 3'b010;
    for (int i = 0; i < 4; i++) begin
      step(1);
      i_inv_add = '0;
      check("t4_stall_valid", o_coin_valid, 1);
      check("t4_stall_idx", o_coin_idx, 2);
    end
    check("t4_stall_inv", dut.r_inv, 24'h070607);
    i_coin_ready = 1'b1;
    step(1);
    check("t4_done", o_done, 1);
    check("t4_ret", o_return_total, 1000);
    check("t4_inv", dut.r_inv, 24'h060607);
    step(1);

    // deposit and eject of the same coin in one cycle
    i_coin_ready = 1'b0;
    i_current_total = 31'd500;
    i_trigger_return = 1'b1;
    step(1);
    i_trigger_return = 1'b0;
    i_current_total = '0;
    step(1);
    check("t5_idx", o_coin_idx, 1);
    i_coin_ready = 1'b1;
    i_inv_add = 3'b010;
    step(1);
    i_inv_add = '0;
    check("t5_inv_same", dut.r_inv, 24'h060607);
    check("t5_done", o_done, 1);
    step(1);

    // saturation at 255
    i_inv_load = 1'b1;
    i_inv_counts = {8'd0, 8'd255, 8'd0};
    step(1);
    i_inv_load = 1'b0;
    i_inv_add = 3'b010;
    step(1);
    i_inv_add = '0;
    check("t5_sat", dut.r_inv, 24'h00FF00);

    // short inventory leaves a residual
    i_inv_load = 1'b1;
    i_inv_counts = {8'd0, 8'd1, 8'd2};
    step(1);
    i_inv_load = 1'b0;
    i_current_total = 31'd2000;
    i_trigger_return = 1'b1;
    step(1);
    i_trigger_return = 1'b0;
    i_current_total = '0;
    step(1);
    check("t6_c0_idx", o_coin_idx, 1);
    step(1);
    check("t6_c1_idx", o_coin_idx, 0);
    check("t6_c1_ret", o_return_total, 500);
    step(1);
    check("t6_c2_idx", o_coin_idx, 0);
    check("t6_c2_ret", o_return_total, 600);
    step(1);
    check("t6_done", o_done, 1);
    check("t6_resid", o_residual, 1300);
    check("t6_ret", o_return_total, 700);
    step(1);

    // trigger with zero balance
    i_trigger_return = 1'b1;
    step(1);
    i_trigger_return = 1'b0;
    step(1);
    check("t7_done", o_done, 1);
    check("t7_ret", o_return_total, 0);
    check("t7_resid", o_residual, 0);
    step(1);

    // reset in the middle of a dispense
    i_inv_load = 1'b1;
    i_inv_counts = {8'd8, 8'd8, 8'd8};
    step(1);
    i_inv_load = 1'b0;
    i_coin_ready = 1'b0;
    i_current_total = 31'd1600;
    i_trigger_return = 1'b1;
    step(1);
    i_trigger_return = 1'b0;
    i_current_total = '0;
    step(1);
    check("t8_pre_valid", o_coin_valid, 1);
    reset_n = 1'b0;
    step(1);
    check("t8_valid", o_coin_valid, 0);
    check("t8_busy", o_busy, 0);
    check("t8_done", o_done, 0);
    check("t8_ret", o_return_total, 0);
    check("t8_resid", o_residual, 0);
    check("t8_wait", o_wait_time, 10);
    check("t8_state", dut.r_state, ST_IDLE);
    check("t8_inv", dut.r_inv, 24'h000000);
    reset_n = 1'b1;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/return_change_ctrl.md
RETURN_CHANGE_CTRL -- requirements
Module: return_change_ctrl

Interface
REQ-001 SHALL have parameter NUM_COINS, default 3, number of coin denominations.
REQ-002 SHALL have parameter TOTAL_BITS, default 31, width of every money value.
REQ-003 SHALL have parameter WAIT_CYCLES, default 10, idle cycles before automatic return.
REQ-004 SHALL have parameter INV_BITS, default 8, width of each per-coin inventory counter.
REQ-005 SHALL have port clk  input  1  clock; reset reset_n, synchronous, active-low; clock clk.
REQ-006 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port i_coin_values  input  NUM_COINS*TOTAL_BITS  packed denominations, index 0 smallest, strictly ascending.
REQ-008 SHALL have port i_current_total  input  TOTAL_BITS  customer balance held upstream.
REQ-009 SHALL have port i_activity  input  1  coin inserted or item bought this cycle.
REQ-010 SHALL have port i_trigger_return  input  1  user return request.
REQ-011 SHALL have port i_inv_load  input  1  load all inventory counters.
REQ-012 SHALL have port i_inv_counts  input  NUM_COINS*INV_BITS  values for i_inv_load.
REQ-013 SHALL have port i_inv_add  input  NUM_COINS  per-coin "one coin deposited" strobe.
REQ-014 SHALL have port i_coin_ready  input  1  coin ejector accepts o_coin_idx.
REQ-015 SHALL have port o_coin_valid  output  1  one coin to eject is presented.
REQ-016 SHALL have port o_coin_idx  output  $clog2(NUM_COINS)  denomination index presented.
REQ-017 SHALL have port o_return_total  output  TOTAL_BITS  value ejected this session.
REQ-018 SHALL have port o_residual  output  TOTAL_BITS  value not returnable, valid with o_done.
REQ-019 SHALL have port o_done  output  1  one-cycle end-of-return pulse.
REQ-020 SHALL have port o_busy  output  1  high in DISPENSE and DONE.
REQ-021 SHALL have port o_wait_time  output  $clog2(WAIT_CYCLES+1)  remaining countdown.

Function
REQ-022 SHALL implement FSM IDLE, COUNT, DISPENSE, DONE; all registers update on posedge clk.
REQ-023 IDLE: timer held at WAIT_CYCLES; i_current_total!=0 -> COUNT; i_trigger_return -> DISPENSE (priority).
REQ-024 COUNT: timer decrements by 1 per cycle, i_activity reloads WAIT_CYCLES, i_trigger_return overrides i_activity.
REQ-025 COUNT -> DISPENSE when i_trigger_return, or timer reaches 0 (exactly WAIT_CYCLES cycles after last reload); COUNT -> IDLE if i_current_total==0.
REQ-026 Entering DISPENSE SHALL latch remaining=i_current_total and clear o_return_total; i_current_total ignored thereafter.
REQ-027 DISPENSE: selected coin = highest k with value[k]<=remaining and inv[k]!=0; o_coin_valid=1, o_coin_idx=k, driven from registered state only.
REQ-028 On o_coin_valid&&i_coin_ready: remaining-=value[k], inv[k]-=1, o_return_total+=value[k]; one coin per cycle max.
REQ-029 o_coin_valid/o_coin_idx SHALL stay stable while i_coin_ready low; i_inv_add SHALL NOT change the presented coin until acceptance.
REQ-030 No eligible coin -> DONE; DONE asserts o_done one cycle, o_residual=remaining, then IDLE; o_residual holds until next DISPENSE entry.
REQ-031 Trigger with zero balance SHALL pass DISPENSE->DONE with o_return_total=0, o_residual=0.
REQ-032 Inventory: i_inv_load overrides all; else inv[k] += i_inv_add[k] - accept[k]; add+accept same coin -> unchanged; increment saturates at 2^INV_BITS-1.
REQ-033 All arithmetic SHALL be unsigned TOTAL_BITS; remaining never underflows by construction of REQ-027.

Reset
REQ-034 reset_n low SHALL force IDLE, timer=WAIT_CYCLES, inventory=0, remaining=0, o_return_total=0, o_residual=0, o_done=0, o_coin_valid=0, o_busy=0, including mid-DISPENSE.

Structure
REQ-035 Package vending_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-036 Sub-module coin_select SHALL implement the combinational greedy priority selection (valid, index) of REQ-027.

Verification (values 100/500/1000, WAIT_CYCLES=10, inventory 8 each)
REQ-037 Balance 1600, trigger, ready=1 -> idx 2,1,0 on consecutive cycles, o_return_total=1600, o_done, o_residual=0.
REQ-038 Balance 500, no activity -> DISPENSE 10 cycles after COUNT entry; activity at countdown 5 -> 10 further cycles.
REQ-039 Ready low 4 cycles during DISPENSE -> valid and idx unchanged, no inventory change until ready.
REQ-040 Inventory {2,1,0}, balance 2000 -> ejects 500,100,100; o_residual=1300.
REQ-041 Reset asserted mid-DISPENSE -> next cycle all outputs at REQ-034 values, FSM IDLE.
REQ-042 i_inv_add[1] with accepted idx 1 same cycle -> inv[1] unchanged; add at max -> stays at 255.
